// File: rtl/shifter_pkg.sv
// Shared shifter definitions: mode encoding and its width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shifter_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_SLL = 2'b00,
        MODE_SRA = 2'b01,
        MODE_ROR = 2'b10,
        MODE_SRL = 2'b11
    } shift_mode_e;

endpackage

// File: rtl/shift_stage.sv
// One shifter pipeline stage: conditional 2^K shift in the carried mode, then a register.
// Latency: 1 cycle from stage input to registered output.
// Backpressure: loads only when adv=1; a valid entry is frozen while adv=0.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4,
    parameter int SHW   = 4,
    parameter int K     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    input  logic              up_vld,
    input  logic [WIDTH-1:0]  up_data,
    input  logic [SHW-1:0]    up_amt,
    input  shift_mode_e       up_mode,
    input  logic [TAG_W-1:0]  up_tag,
    output logic              vld_q,
    output logic [WIDTH-1:0]  data_q,
    output logic [SHW-1:0]    amt_q,
    output shift_mode_e       mode_q,
    output logic [TAG_W-1:0]  tag_q
);

    localparam int S = 1 << K;

    logic [WIDTH-1:0] shifted;

    // Apply this stage's fixed 2^K shift when amount bit K is set
    always_comb begin
        shifted = up_data;
        if (up_amt[K]) begin
            case (up_mode)
                MODE_SLL: shifted = up_data << S;
                MODE_SRL: shifted = up_data >> S;
                MODE_SRA: shifted = $signed(up_data) >>> S;
                MODE_ROR: shifted = (up_data >> S) | (up_data << (WIDTH - S));
                default:  shifted = up_data;
            endcase
        end
    end

    // Stage register: valid follows adv, payload only loads for a real operation
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            amt_q  <= '0;
            mode_q <= MODE_SLL;
            tag_q  <= '0;
        end else if (adv) begin
            vld_q <= up_vld;
            if (up_vld) begin
                data_q <= shifted;
                amt_q  <= up_amt;
                mode_q <= up_mode;
                tag_q  <= up_tag;
            end
        end
    end

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter (SLL/SRA/ROR/SRL) with sideband tag; optional flags via PIPE_SHIFTER_FLAGS_EN.
// Latency: log2(WIDTH) cycles, one operation per cycle when out_ready stays high.
// Backpressure: valid/ready; empty stages always fill, in_ready is combinational from out_ready.
module pipe_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [SHW-1:0]    in_amt,
    input  logic [1:0]        in_mode,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [TAG_W-1:0]  out_tag
`ifdef PIPE_SHIFTER_FLAGS_EN
    ,
    output logic              out_zero,
    output logic              out_neg
`endif
);

    // Index 0 is the input port; index k+1 is the register of stage k.
    logic              vld_a  [SHW+1];
    logic [WIDTH-1:0]  data_a [SHW+1];
    logic [SHW-1:0]    amt_a  [SHW+1];
    shift_mode_e       mode_a [SHW+1];
    logic [TAG_W-1:0]  tag_a  [SHW+1];
    logic [SHW-1:0]    adv;

    // The last stage's amount and mode have no consumer past the pipeline.
    logic [SHW-1:0]    unused_amt;
    shift_mode_e       unused_mode;

    assign vld_a[0]  = in_valid;
    assign data_a[0] = in_data;
    assign amt_a[0]  = in_amt;
    assign mode_a[0] = shift_mode_e'(in_mode);
    assign tag_a[0]  = in_tag;

    // Stage k may load when any stage from k to the end has a hole, or the consumer takes the result
    always_comb begin
        adv = '0;
        for (int k = 0; k < SHW; k++) begin
            adv[k] = out_ready;
            for (int j = k; j < SHW; j++) begin
                if (!vld_a[j+1]) adv[k] = 1'b1;
            end
        end
    end

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .SHW   (SHW),
            .K     (k)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .adv     (adv[k]),
            .up_vld  (vld_a[k]),
            .up_data (data_a[k]),
            .up_amt  (amt_a[k]),
            .up_mode (mode_a[k]),
            .up_tag  (tag_a[k]),
            .vld_q   (vld_a[k+1]),
            .data_q  (data_a[k+1]),
            .amt_q   (amt_a[k+1]),
            .mode_q  (mode_a[k+1]),
            .tag_q   (tag_a[k+1])
        );
    end

    assign in_ready    = adv[0];
    assign out_valid   = vld_a[SHW];
    assign out_data    = data_a[SHW];
    assign out_tag     = tag_a[SHW];
    assign unused_amt  = amt_a[SHW];
    assign unused_mode = mode_a[SHW];

`ifdef PIPE_SHIFTER_FLAGS_EN
    localparam int LAST_S = 1 << (SHW - 1);

    logic [WIDTH-1:0] last_nxt;

    // Recompute the value the last stage is about to load so the flags register alongside it
    always_comb begin
        last_nxt = data_a[SHW-1];
        if (amt_a[SHW-1][SHW-1]) begin
            case (mode_a[SHW-1])
                MODE_SLL: last_nxt = data_a[SHW-1] << LAST_S;
                MODE_SRL: last_nxt = data_a[SHW-1] >> LAST_S;
                MODE_SRA: last_nxt = $signed(data_a[SHW-1]) >>> LAST_S;
                MODE_ROR: last_nxt = (data_a[SHW-1] >> LAST_S) | (data_a[SHW-1] << (WIDTH - LAST_S));
                default:  last_nxt = data_a[SHW-1];
            endcase
        end
    end

    // Flags share the last stage's load enable, so they hold under stall
    always_ff @(posedge clk) begin
        if (rst) begin
            out_zero <= 1'b0;
            out_neg  <= 1'b0;
        end else if (adv[SHW-1] && vld_a[SHW-1]) begin
            out_zero <= (last_nxt == '0);
            out_neg  <= last_nxt[WIDTH-1];
        end
    end
`endif

endmodule
